// File: rtl/ysyx_24080006_pkg.sv
// ysyx_24080006_pkg: shared AXI bus types, response codes and CLINT register map helpers.
package ysyx_24080006_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        logic       bvalid;
        logic [1:0] bresp;
    } axi_w_s2m_t;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } axi_r_s2m_t;

    typedef enum logic [1:0] {REG_NONE, REG_MSIP, REG_MTIMECMP, REG_MTIME} clint_reg_e;

    typedef struct packed {
        clint_reg_e kind;
        logic [2:0] hart;
        logic       hi;
    } clint_dec_t;

    function automatic clint_dec_t clint_decode(input logic [15:0] off, input int num_harts);
        clint_dec_t d;
        d.kind = REG_NONE;
        d.hart = 3'd0;
        d.hi   = off[2];
        if (off < CLINT_MSIP_OFF + 16'(4 * num_harts)) begin
            d.kind = REG_MSIP;
            d.hart = off[4:2];
        end else if (off >= CLINT_MTIMECMP_OFF && off < CLINT_MTIMECMP_OFF + 16'(8 * num_harts)) begin
            d.kind = REG_MTIMECMP;
            d.hart = off[5:3];
        end else if (off[15:3] == CLINT_MTIME_OFF[15:3]) begin
            d.kind = REG_MTIME;
        end
        return d;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/ysyx_24080006_aclint_tick.sv
// ysyx_24080006_aclint_tick: tick divider and 64-bit mtime; a word write overrides the tick that cycle.
module ysyx_24080006_aclint_tick #(
    parameter int TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] mtime
);

    logic [15:0] div;
    logic        tick;

    assign tick = div == 16'(TICK_DIV - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div   <= '0;
            mtime <= '0;
        end else begin
            div <= tick ? '0 : div + 16'd1;
            if (wr_lo) mtime[31:0] <= wr_data;
            else if (wr_hi) mtime[63:32] <= wr_data;
            else if (tick) mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/ysyx_24080006_aclint.sv
// ysyx_24080006_aclint: multi-hart CLINT with mtime/mtimecmp/msip behind an AXI-lite style slave port.
module ysyx_24080006_aclint
    import ysyx_24080006_pkg::*;
#(
    parameter int NUM_HARTS = 1,
    parameter int TICK_DIV  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  axi_w_m2s_t           clint_w_m2s,
    output axi_w_s2m_t           clint_w_s2m,
    input  axi_r_m2s_t           clint_r_m2s,
    output axi_r_s2m_t           clint_r_s2m,
    output logic [NUM_HARTS-1:0] mtip_o,
    output logic [NUM_HARTS-1:0] msip_o
);

    typedef enum logic {R_IDLE, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;

    r_state_e             r_state, r_next;
    w_state_e             w_state, w_next;
    logic [63:0]          mtime;
    logic [63:0]          mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip;
    logic [31:0]          rdata_q, rd_word, wr_new, w_data;
    logic [1:0]           rresp_q, bresp_q;
    logic [15:0]          aw_off;
    logic [3:0]           w_strb;
    logic                 aw_held, w_held, aw_hs, w_hs, w_exec, wr_lo, wr_hi;
    clint_dec_t           rdec, wdec;
    logic                 unused_addr;

    // The crossbar already selected this slave; upper address bits carry no meaning here.
    assign unused_addr = ^{clint_w_m2s.awaddr[31:16], clint_r_m2s.araddr[31:16]};

    function automatic logic [31:0] reg_word(input clint_dec_t d);
        logic [31:0] v;
        v = d.kind == REG_MTIME ? (d.hi ? mtime[63:32] : mtime[31:0]) : 32'd0;
        for (int h = 0; h < NUM_HARTS; h++)
            if (d.hart == 3'(h))
                v = d.kind == REG_MSIP ? {31'd0, msip[h]} :
                    d.kind == REG_MTIMECMP ? (d.hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0]) : v;
        return v;
    endfunction

    assign rdec = clint_decode(clint_r_m2s.araddr[15:0], NUM_HARTS);
    assign wdec = clint_decode(aw_off, NUM_HARTS);

    always_comb begin
        rd_word = reg_word(rdec);
        wr_new  = apply_wstrb(reg_word(wdec), w_data, w_strb);
    end

    always_comb begin
        r_next = r_state == R_IDLE ? (clint_r_m2s.arvalid ? R_RESP : R_IDLE)
                                   : (clint_r_m2s.rready ? R_IDLE : R_RESP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= AXI_RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && clint_r_m2s.arvalid) begin
                rdata_q <= rd_word;
                rresp_q <= rdec.kind == REG_NONE ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

    assign clint_r_s2m = '{arready: r_state == R_IDLE, rvalid: r_state == R_RESP,
                           rdata: rdata_q, rresp: rresp_q, rlast: 1'b1};

    assign aw_hs  = w_state == W_IDLE && !aw_held && clint_w_m2s.awvalid;
    assign w_hs   = w_state == W_IDLE && !w_held && clint_w_m2s.wvalid;
    assign w_exec = w_state == W_EXEC;
    assign wr_lo  = w_exec && wdec.kind == REG_MTIME && !wdec.hi;
    assign wr_hi  = w_exec && wdec.kind == REG_MTIME && wdec.hi;

    always_comb begin
        w_next = w_state == W_EXEC ? W_RESP :
                 w_state == W_RESP ? (clint_w_m2s.bready ? W_IDLE : W_RESP) :
                 ((aw_held || aw_hs) && (w_held || w_hs)) ? W_EXEC : W_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_off  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= AXI_RESP_OKAY;
            msip    <= '0;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_off  <= clint_w_m2s.awaddr[15:0];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= clint_w_m2s.wdata;
                w_strb <= clint_w_m2s.wstrb;
            end
            if (w_state == W_RESP && clint_w_m2s.bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (w_exec) begin
                bresp_q <= wdec.kind == REG_NONE ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                for (int h = 0; h < NUM_HARTS; h++)
                    if (wdec.hart == 3'(h)) begin
                        if (wdec.kind == REG_MSIP) msip[h] <= wr_new[0];
                        if (wdec.kind == REG_MTIMECMP && wdec.hi) mtimecmp[h][63:32] <= wr_new;
                        if (wdec.kind == REG_MTIMECMP && !wdec.hi) mtimecmp[h][31:0] <= wr_new;
                    end
            end
        end
    end

    assign clint_w_s2m = '{awready: w_state == W_IDLE && !aw_held, wready: w_state == W_IDLE && !w_held,
                           bvalid: w_state == W_RESP, bresp: bresp_q};

    ysyx_24080006_aclint_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .wr_lo  (wr_lo),
        .wr_hi  (wr_hi),
        .wr_data(wr_new),
        .mtime  (mtime)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mtip_o <= '0;
        else for (int h = 0; h < NUM_HARTS; h++) mtip_o[h] <= mtime >= mtimecmp[h];
    end

    assign msip_o = msip;

endmodule

// File: tb/tb_ysyx_24080006_aclint.sv
// tb_ysyx_24080006_aclint: directed checks on a 2-hart/div-1 and a 1-hart/div-4 CLINT sharing one bus.
module tb_ysyx_24080006_aclint;
    import ysyx_24080006_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    axi_w_m2s_t wm;
    axi_r_m2s_t rm;
    axi_w_s2m_t ws1, ws4;
    axi_r_s2m_t rs1, rs4;
    logic [1:0] mtip1, msip1;
    logic [0:0] mtip4, msip4;
    int         errors = 0, checks = 0, cyc = 0;
    logic [31:0] d1, d4;
    logic [1:0]  r1, r4;
    int          a;

    always #5 clock = ~clock;
    always @(posedge clock) if (!reset) cyc++;

    ysyx_24080006_aclint #(.NUM_HARTS(2), .TICK_DIV(1)) dut1 (
        .clock(clock), .reset(reset), .clint_w_m2s(wm), .clint_w_s2m(ws1),
        .clint_r_m2s(rm), .clint_r_s2m(rs1), .mtip_o(mtip1), .msip_o(msip1));

    ysyx_24080006_aclint #(.NUM_HARTS(1), .TICK_DIV(4)) dut4 (
        .clock(clock), .reset(reset), .clint_w_m2s(wm), .clint_w_s2m(ws4),
        .clint_r_m2s(rm), .clint_r_s2m(rs4), .mtip_o(mtip4), .msip_o(msip4));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input int hold, output logic [31:0] o1, output logic [1:0] p1,
                      output logic [31:0] o4, output logic [1:0] p4);
        rm.arvalid = 1'b1;
        rm.araddr  = addr;
        rm.rready  = hold == 0;
        chk("rvalid_before_ar", rs1.rvalid, 1'b0);
        step;
        rm.arvalid = 1'b0;
        chk("rvalid_latency", {rs1.rvalid, rs1.arready, rs4.rvalid}, 3'b101);
        o1 = rs1.rdata; p1 = rs1.rresp; o4 = rs4.rdata; p4 = rs4.rresp;
        repeat (hold) begin
            step;
            chk("rdata_hold", {rs1.rvalid, rs1.arready, rs1.rdata}, {2'b10, o1});
        end
        rm.rready = 1'b1;
        step;
        chk("r_return_idle", {rs1.rvalid, rs1.arready}, 2'b01);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      output logic [1:0] p1, output logic [1:0] p4);
        int n;
        wm.awvalid = 1'b1; wm.awaddr = addr;
        wm.wvalid = 1'b1; wm.wdata = data; wm.wstrb = strb; wm.bready = 1'b1;
        step;
        wm.awvalid = 1'b0; wm.wvalid = 1'b0;
        chk("aw_w_accepted", {ws1.awready, ws1.wready}, 2'b00);
        n = 0;
        while (!ws1.bvalid && n < 8) begin
            step;
            n++;
        end
        chk("b_latency", n, 1);
        p1 = ws1.bresp; p4 = ws4.bresp;
        step;
        chk("bvalid_clear", {ws1.bvalid, ws1.awready, ws1.wready}, 3'b011);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        wm = '0; wm.bready = 1'b1;
        rm = '0; rm.rready = 1'b1;
        repeat (3) step;
        chk("rst_r1", {rs1.arready, rs1.rvalid, rs1.rdata, rs1.rresp, rs1.rlast}, {2'b10, 32'd0, 2'b00, 1'b1});
        chk("rst_r4", {rs4.arready, rs4.rvalid, rs4.rdata, rs4.rresp, rs4.rlast}, {2'b10, 32'd0, 2'b00, 1'b1});
        chk("rst_w1", {ws1.awready, ws1.wready, ws1.bvalid, ws1.bresp}, 5'b11000);
        chk("rst_irq", {mtip1, msip1, mtip4, msip4}, 6'd0);
        reset = 1'b0;
        // Edge k after release: div-1 mtime = k, div-4 mtime = k/4.
        repeat (4) step;
        rd(32'h0200_BFF8, 0, d1, r1, d4, r4);
        chk("mtime_div1_at5", d1, 32'd4);
        chk("mtime_resp", r1, AXI_RESP_OKAY);
        chk("mtime_div4_first", d4, 32'd1);
        repeat (38) step;
        rd(32'h0200_BFF8, 0, d1, r1, d4, r4);
        chk("mtime_div1_at45", d1, 32'd44);
        chk("mtime_div4_plus10", d4, 32'd11);
        rd(32'h0200_BFFC, 0, d1, r1, d4, r4);
        chk("mtime_hi", {d1, d4}, 64'd0);
        wr(32'h0200_4000, 32'd20, 4'hF, r1, r4);
        chk("cmp_lo_resp", {r1, r4}, {AXI_RESP_OKAY, AXI_RESP_OKAY});
        chk("mtip_cmp_lo_only", {mtip1, mtip4}, 3'b000);
        wr(32'h0200_4004, 32'd0, 4'hF, r1, r4);
        chk("mtip1_after_cmp", mtip1, 2'b01);
        repeat (26) step;
        chk("mtip4_before", mtip4, 1'b0);
        step;
        chk("mtip4_rise", mtip4, 1'b1);
        wr(32'h0200_4004, 32'hFFFF_FFFF, 4'hF, r1, r4);
        chk("mtip_drop", {mtip1, mtip4}, 3'b000);
        wr(32'h0200_0004, 32'd1, 4'hF, r1, r4);
        chk("msip1_set_resp", {r1, r4}, {AXI_RESP_OKAY, AXI_RESP_SLVERR});
        chk("msip_hart1", {msip1, msip4}, 3'b100);
        wr(32'h0200_0004, 32'hFFFF_FFFE, 4'hF, r1, r4);
        chk("msip_clear", {msip1, msip4}, 3'b000);
        rd(32'h0200_0004, 0, d1, r1, d4, r4);
        chk("msip1_read", {d1, r1}, {32'd0, AXI_RESP_OKAY});
        chk("msip4_unmapped", {d4, r4}, {32'd0, AXI_RESP_SLVERR});
        wr(32'h0200_0000, 32'd1, 4'b1110, r1, r4);
        chk("msip_strb_masked", {msip1, msip4}, 3'b000);
        wr(32'h0200_0000, 32'd1, 4'b0001, r1, r4);
        chk("msip_strb0", {msip1, msip4}, 3'b011);
        rd(32'h0200_0000, 2, d1, r1, d4, r4);
        chk("msip_read_hold", {d1, d4}, {32'd1, 32'd1});
        // Read and write of msip0 land on the same edge: the read sees the old value.
        wm.awvalid = 1'b1; wm.awaddr = 32'h0200_0000; wm.wvalid = 1'b1; wm.wdata = 32'd0; wm.wstrb = 4'hF;
        step;
        wm.awvalid = 1'b0; wm.wvalid = 1'b0;
        rm.arvalid = 1'b1; rm.araddr = 32'h0200_0000;
        step;
        rm.arvalid = 1'b0;
        chk("rw_same_edge", {rs1.rvalid, ws1.bvalid, rs1.rdata, rs4.rdata}, {2'b11, 32'd1, 32'd1});
        step;
        chk("rw_after", {msip1, msip4, rs1.rvalid, ws1.bvalid}, 5'b00000);
        wm.wvalid = 1'b1; wm.wdata = 32'h1234_5678; wm.wstrb = 4'hF;
        step;
        chk("w_first_accept", {ws1.wready, ws1.awready, ws1.bvalid}, 3'b010);
        wm.wdata = 32'hDEAD_BEEF;
        step;
        step;
        chk("w_waiting_aw", {ws1.bvalid, ws1.wready}, 2'b00);
        wm.awvalid = 1'b1; wm.awaddr = 32'h0200_4008;
        step;
        chk("aw_accept", ws1.awready, 1'b0);
        wm.bready = 1'b0;
        step;
        chk("b_after_exec", {ws1.bvalid, ws1.bresp, ws4.bresp}, {1'b1, AXI_RESP_OKAY, AXI_RESP_SLVERR});
        step;
        chk("b_hold1", {ws1.bvalid, ws1.awready, ws1.wready}, 3'b100);
        step;
        chk("b_hold2", {ws1.bvalid, ws1.awready, ws1.wready}, 3'b100);
        wm.awvalid = 1'b0; wm.wvalid = 1'b0; wm.bready = 1'b1;
        step;
        chk("b_release", {ws1.bvalid, ws1.awready, ws1.wready}, 3'b011);
        rd(32'h0200_4008, 0, d1, r1, d4, r4);
        chk("cmp1_lo", {d1, r1}, {32'h1234_5678, AXI_RESP_OKAY});
        chk("cmp1_lo_dut4", {d4, r4}, {32'd0, AXI_RESP_SLVERR});
        rd(32'h0200_400C, 0, d1, r1, d4, r4);
        chk("cmp1_hi", d1, 32'hFFFF_FFFF);
        rd(32'h0200_0008, 0, d1, r1, d4, r4);
        chk("unmapped_read", {d1, r1}, {32'd0, AXI_RESP_SLVERR});
        wr(32'h0200_1234, 32'hFFFF_FFFF, 4'hF, r1, r4);
        chk("unmapped_write", {r1, r4}, {AXI_RESP_SLVERR, AXI_RESP_SLVERR});
        chk("unmapped_no_change", {msip1, msip4, mtip1, mtip4}, 6'd0);
        rd(32'h0200_4008, 0, d1, r1, d4, r4);
        chk("cmp1_kept", d1, 32'h1234_5678);
        // Align the low-word write onto a div-4 tick edge (edges that are multiples of 4).
        while ((cyc + 2) % 4 != 0) step;
        a = cyc + 2;
        wr(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, r1, r4);
        chk("wrap_lo_resp", r1, AXI_RESP_OKAY);
        wr(32'h0200_BFFC, 32'd0, 4'hF, r1, r4);
        chk("wrap_timing", cyc, a + 4);
        rd(32'h0200_BFFC, 0, d1, r1, d4, r4);
        chk("hi_write_beats_carry", d1, 32'd0);
        chk("div4_wrap_hi", d4, 32'd1);
        rd(32'h0200_BFF8, 0, d1, r1, d4, r4);
        chk("lo_no_tick_on_write", d1, 32'd4);
        chk("div4_wrap_lo", d4, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
